// File: rtl/packet_inspect_arbiter.sv
// packet_inspect_arbiter: round-robin, packet-atomic arbiter in front of the packet inspector,
// with a mid-packet stall timeout that injects an empty terminating beat.
module packet_inspect_arbiter #(
  parameter int N_PORTS        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ID_W           = $clog2(N_PORTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [N_PORTS-1:0]    port_mask,
  input  logic [N_PORTS-1:0]    s_valid,
  input  logic [N_PORTS*64-1:0] s_data,
  input  logic [N_PORTS*8-1:0]  s_keep,
  input  logic [N_PORTS-1:0]    s_last,
  output logic [N_PORTS-1:0]    s_ready,
  output logic                  m_valid,
  output logic [63:0]           m_data,
  output logic [7:0]            m_keep,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  grant_valid,
  output logic [ID_W-1:0]       grant_id,
  output logic                  timeout_pulse,
  output logic [ID_W-1:0]       timeout_port,
  output logic [31:0]           pkt_count
);
  typedef enum logic [1:0] {IDLE, PASS, FLUSH} state_t;
  localparam logic [15:0]     TO   = 16'(TIMEOUT_CYCLES);
  localparam logic [ID_W-1:0] LAST = ID_W'(N_PORTS - 1);
  state_t          state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d, last_grant_q, last_grant_d;
  logic [ID_W-1:0] timeout_port_q, timeout_port_d, pick;
  logic [15:0]     stall_q, stall_d;
  logic [31:0]     pkt_count_q, pkt_count_d;
  logic            timeout_pulse_q, timeout_pulse_d;
  logic [N_PORTS-1:0] req;
  logic            found;
  logic            g_valid, g_last;
  logic [63:0]     g_data;
  logic [7:0]      g_keep;
  // Round-robin scan starting one past the previous owner, wrapping.
  always_comb begin
    req   = s_valid & port_mask;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_PORTS; k++) begin
      if (!found && req[(int'(last_grant_q) + k) % N_PORTS]) begin
        found = 1'b1;
        pick  = ID_W'((int'(last_grant_q) + k) % N_PORTS);
      end
    end
  end
  always_comb begin
    g_valid     = s_valid[grant_id_q];
    g_last      = s_last[grant_id_q];
    g_data      = s_data[int'(grant_id_q)*64 +: 64];
    g_keep      = s_keep[int'(grant_id_q)*8 +: 8];
    m_valid     = state_q == PASS ? g_valid : state_q == FLUSH;
    m_data      = state_q == PASS ? g_data : '0;
    m_keep      = state_q == PASS ? g_keep : '0;
    m_last      = state_q == PASS ? g_last : state_q == FLUSH;
    s_ready     = state_q == PASS ? {{(N_PORTS-1){1'b0}}, m_ready} << grant_id_q : '0;
    grant_valid = state_q != IDLE;
  end
  always_comb begin
    state_d         = state_q;
    grant_id_d      = grant_id_q;
    last_grant_d    = last_grant_q;
    timeout_port_d  = timeout_port_q;
    stall_d         = stall_q;
    pkt_count_d     = pkt_count_q;
    timeout_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        stall_d = '0;
        if (enable && found) begin
          grant_id_d = pick;
          state_d    = PASS;
        end
      end
      PASS: begin
        if (m_valid && m_ready) begin
          stall_d = '0;
          if (m_last) begin
            pkt_count_d  = pkt_count_q + 32'd1;
            last_grant_d = grant_id_q;
            state_d      = IDLE;
          end
        end else if (!g_valid) begin
          // Only a silent source counts as a stall; inspector backpressure never does.
          stall_d = stall_q + 16'd1;
          if (TO != 16'd0 && stall_d == TO) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (m_ready) begin
          timeout_pulse_d = 1'b1;
          timeout_port_d  = grant_id_q;
          pkt_count_d     = pkt_count_q + 32'd1;
          last_grant_d    = grant_id_q;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      grant_id_q      <= '0;
      last_grant_q    <= LAST;
      timeout_port_q  <= '0;
      stall_q         <= '0;
      pkt_count_q     <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_id_q      <= grant_id_d;
      last_grant_q    <= last_grant_d;
      timeout_port_q  <= timeout_port_d;
      stall_q         <= stall_d;
      pkt_count_q     <= pkt_count_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end
  assign grant_id      = grant_id_q;
  assign timeout_pulse = timeout_pulse_q;
  assign timeout_port  = timeout_port_q;
  assign pkt_count     = pkt_count_q;
endmodule

// File: tb/tb_packet_inspect_arbiter.sv
// tb_packet_inspect_arbiter: scenario tasks drive per-port packet sources; a scoreboard queue holds
// the beats the inspector side must see, in order.
module tb_packet_inspect_arbiter;
  localparam int N = 4;
  typedef struct packed {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1, m_ready = 1'b1;
  logic [N-1:0] port_mask = 4'hF, s_valid, s_last, s_ready;
  logic [N*64-1:0] s_data;
  logic [N*8-1:0] s_keep;
  logic m_valid, m_last, grant_valid, timeout_pulse;
  logic [63:0] m_data;
  logic [7:0] m_keep;
  logic [1:0] grant_id, timeout_port;
  logic [31:0] pkt_count;
  beat_t src [N][32];
  int len [N], ptr [N];
  beat_t sbq [$];
  beat_t e;
  int n_checks = 0, n_fail = 0;
  logic snap_gv, snap_mv, snap_mr, snap_last, snap_tp;
  logic [1:0] snap_gid, snap_tport;
  logic [7:0] snap_keep;
  logic [31:0] snap_cnt;
  logic [N-1:0] granted_seen;
  always #5 clk = ~clk;
  packet_inspect_arbiter #(.N_PORTS(N), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .port_mask(port_mask),
    .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_ready(m_ready),
    .grant_valid(grant_valid), .grant_id(grant_id), .timeout_pulse(timeout_pulse),
    .timeout_port(timeout_port), .pkt_count(pkt_count)
  );
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected got %h/%h/%b with empty scoreboard", m_data, m_keep, m_last);
      end else begin
        e = sbq.pop_front();
        if ({m_data, m_keep, m_last} !== e) begin
          n_fail++;
          $display("FAIL beat got %h/%h/%b expected %h/%h/%b", m_data, m_keep, m_last, e.d, e.k, e.l);
        end
      end
    end
  end
  task automatic drive();
    for (int p = 0; p < N; p++) begin
      s_valid[p]         = ptr[p] < len[p];
      s_data[p*64 +: 64] = ptr[p] < len[p] ? src[p][ptr[p]].d : 64'h0;
      s_keep[p*8 +: 8]   = ptr[p] < len[p] ? src[p][ptr[p]].k : 8'h0;
      s_last[p]          = ptr[p] < len[p] ? src[p][ptr[p]].l : 1'b0;
    end
  endtask
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = s_valid & s_ready;
    snap_gv = grant_valid; snap_gid = grant_id; snap_mv = m_valid; snap_mr = m_ready;
    snap_keep = m_keep; snap_last = m_last; snap_tp = timeout_pulse; snap_tport = timeout_port;
    snap_cnt = pkt_count;
    if (grant_valid) granted_seen[grant_id] = 1'b1;
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) if (acc[p]) ptr[p]++;
    drive();
  endtask
  task automatic clear_src();
    for (int p = 0; p < N; p++) begin len[p] = 0; ptr[p] = 0; end
    sbq.delete();
    granted_seen = '0;
    drive();
  endtask
  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; port_mask = 4'hF; m_ready = 1'b1;
    clear_src();
    tick(); tick();
    rst = 1'b0;
  endtask
  task automatic load_pkt(input int p, input int pid, input int nb, input bit term, input bit expect_it);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.d = {16'(p), 16'(pid), 16'(i), 16'hC0DE};
      b.k = (i == nb - 1) ? 8'h0F : 8'hFF;
      b.l = term && (i == nb - 1);
      src[p][len[p]] = b;
      len[p]++;
      if (expect_it) sbq.push_back(b);
    end
    drive();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    clear_src();
    tick(); tick();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b need 0", m_valid); end
    n_checks++; if (s_ready !== 4'h0) begin n_fail++; $display("FAIL reset_s_ready got %b need 0", s_ready); end
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_grant_valid got %b need 0", grant_valid); end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id got %0d need 0", grant_id); end
    n_checks++; if (timeout_pulse !== 1'b0 || timeout_port !== 2'd0) begin n_fail++; $display("FAIL reset_timeout got %b/%0d need 0/0", timeout_pulse, timeout_port); end
    n_checks++; if (pkt_count !== 32'd0) begin n_fail++; $display("FAIL reset_pkt_count got %0d need 0", pkt_count); end
    rst = 1'b0;
  endtask
  task automatic test_single();
    do_reset();
    load_pkt(0, 0, 4, 1'b1, 1'b1);
    tick();
    n_checks++; if (snap_gv !== 1'b0) begin n_fail++; $display("FAIL single_arb_latency got grant_valid %b need 0", snap_gv); end
    tick();
    n_checks++; if (snap_gv !== 1'b1 || snap_gid !== 2'd0) begin n_fail++; $display("FAIL single_grant got %b/%0d need 1/0", snap_gv, snap_gid); end
    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
    n_checks++; if (sbq.size() != 0) begin n_fail++; $display("FAIL single_drain got %0d beats left need 0", sbq.size()); end
    tick();
    n_checks++; if (snap_gv !== 1'b0 || snap_cnt !== 32'd1) begin n_fail++; $display("FAIL single_done got gv %b cnt %0d need 0/1", snap_gv, snap_cnt); end
  endtask
  task automatic test_round_robin();
    int rr [3];
    rr[0] = 0; rr[1] = 1; rr[2] = 3;
    do_reset();
    for (int pid = 0; pid < 2; pid++) for (int j = 0; j < 3; j++) load_pkt(rr[j], pid, 2, 1'b1, 1'b1);
    for (int i = 0; i < 100 && sbq.size() != 0; i++) tick();
    n_checks++; if (sbq.size() != 0) begin n_fail++; $display("FAIL rr_drain got %0d beats left need 0", sbq.size()); end
    tick();
    n_checks++; if (snap_cnt !== 32'd6 || granted_seen !== 4'b1011) begin n_fail++; $display("FAIL rr_done got cnt %0d seen %b need 6/1011", snap_cnt, granted_seen); end
  endtask
  task automatic test_mask_enable();
    logic bad;
    do_reset();
    port_mask = 4'b1101;
    for (int p = 0; p < N; p++) load_pkt(p, 0, 2, 1'b1, p != 1);
    for (int i = 0; i < 100 && sbq.size() != 0; i++) tick();
    n_checks++; if (sbq.size() != 0) begin n_fail++; $display("FAIL mask_drain got %0d beats left need 0", sbq.size()); end
    tick();
    n_checks++; if (granted_seen[1] !== 1'b0 || snap_cnt !== 32'd3) begin n_fail++; $display("FAIL mask_port1 got seen %b cnt %0d need 0/3", granted_seen[1], snap_cnt); end
    load_pkt(0, 1, 3, 1'b1, 1'b1);
    load_pkt(2, 1, 2, 1'b1, 1'b0);
    for (int i = 0; i < 20 && !snap_gv; i++) tick();
    enable = 1'b0;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
    n_checks++; if (sbq.size() != 0) begin n_fail++; $display("FAIL enable_finish got %0d beats left need 0", sbq.size()); end
    granted_seen = '0;
    bad = 1'b0;
    repeat (10) begin tick(); if (snap_gv || snap_mv) bad = 1'b1; end
    n_checks++; if (bad !== 1'b0 || snap_cnt !== 32'd4) begin n_fail++; $display("FAIL enable_hold got regrant %b cnt %0d need 0/4", bad, snap_cnt); end
  endtask
  task automatic test_timeout();
    logic bad;
    do_reset();
    load_pkt(2, 0, 1, 1'b0, 1'b1);
    sbq.push_back(beat_t'{64'h0, 8'h0, 1'b1});
    for (int i = 0; i < 20 && !(snap_mv && snap_mr); i++) tick();
    n_checks++; if (!(snap_mv && snap_mr)) begin n_fail++; $display("FAIL timeout_first_beat got valid %b need 1", snap_mv); end
    bad = 1'b0;
    repeat (8) begin tick(); if (snap_mv) bad = 1'b1; end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL timeout_early got m_valid during stall %b need 0", bad); end
    tick();
    n_checks++; if (snap_mv !== 1'b1 || snap_keep !== 8'h0 || snap_last !== 1'b1 || snap_tp !== 1'b0) begin n_fail++; $display("FAIL timeout_flush got v%b k%h l%b p%b need 1/00/1/0", snap_mv, snap_keep, snap_last, snap_tp); end
    tick();
    n_checks++; if (snap_tp !== 1'b1 || snap_tport !== 2'd2 || snap_cnt !== 32'd1) begin n_fail++; $display("FAIL timeout_pulse got p%b port %0d cnt %0d need 1/2/1", snap_tp, snap_tport, snap_cnt); end
    tick();
    n_checks++; if (snap_tp !== 1'b0 || snap_gv !== 1'b0) begin n_fail++; $display("FAIL timeout_after got p%b gv %b need 0/0", snap_tp, snap_gv); end
  endtask
  task automatic test_backpressure();
    logic bad;
    do_reset();
    load_pkt(1, 0, 3, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !(snap_mv && snap_mr); i++) tick();
    m_ready = 1'b0;
    bad = 1'b0;
    repeat (2000) begin tick(); if (!snap_gv || !snap_mv || snap_tp || snap_keep == 8'h0) bad = 1'b1; end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL bp_no_flush got bad %b need 0", bad); end
    m_ready = 1'b1;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
    tick();
    n_checks++; if (sbq.size() != 0 || snap_cnt !== 32'd1 || snap_tp !== 1'b0) begin n_fail++; $display("FAIL bp_complete got left %0d cnt %0d p%b need 0/1/0", sbq.size(), snap_cnt, snap_tp); end
  endtask
  task automatic test_async_reset();
    do_reset();
    load_pkt(2, 0, 4, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !snap_gv; i++) tick();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (m_valid !== 1'b0 || grant_valid !== 1'b0 || s_ready !== 4'h0) begin n_fail++; $display("FAIL async_rst_out got v%b gv%b r%b need 0/0/0", m_valid, grant_valid, s_ready); end
    n_checks++; if (grant_id !== 2'd0 || pkt_count !== 32'd0) begin n_fail++; $display("FAIL async_rst_regs got id %0d cnt %0d need 0/0", grant_id, pkt_count); end
    clear_src();
    for (int p = 0; p < N; p++) load_pkt(p, 1, 1, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20 && !snap_gv; i++) tick();
    n_checks++; if (snap_gv !== 1'b1 || snap_gid !== 2'd0) begin n_fail++; $display("FAIL tie_after_reset got gv %b id %0d need 1/0", snap_gv, snap_gid); end
    for (int i = 0; i < 40 && sbq.size() != 0; i++) tick();
    tick();
    n_checks++; if (sbq.size() != 0 || snap_cnt !== 32'd4) begin n_fail++; $display("FAIL tie_drain got left %0d cnt %0d need 0/4", sbq.size(), snap_cnt); end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mask_enable();
    test_timeout();
    test_backpressure();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/packet_inspect_arbiter.md
# packet_inspect_arbiter

Shares one 64-bit packet inspector stream port between `N_PORTS` independent packet sources.
- Round-robin, packet-atomic: a grant is held from first beat to `last`, so the inspector never sees interleaved packets.
- Guards the inspector against a granted source that stalls mid-packet: after a timeout it injects a terminating beat and flags the offending port.
- Sits directly in front of the inspector's `packet_*` inputs in the packet processor.

## Interface

Parameters:
- `N_PORTS`, default 4: number of requesters, valid range 2..16.
- `TIMEOUT_CYCLES`, default 1024: mid-packet stall limit. 0 disables the timeout.
- `ID_W`, default `$clog2(N_PORTS)`: width of port indices.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: permits new grants. Does not abort a packet in flight.
- `port_mask` in N_PORTS: bit i=0 excludes port i from arbitration.
- `s_valid` in N_PORTS: per-port beat valid.
- `s_data` in N_PORTS*64: per-port data; port i occupies bits [i*64 +: 64].
- `s_keep` in N_PORTS*8: per-port byte enables; port i occupies bits [i*8 +: 8].
- `s_last` in N_PORTS: per-port end of packet.
- `s_ready` out N_PORTS: per-port ready.
- `m_valid` out 1, `m_data` out 64, `m_keep` out 8, `m_last` out 1: stream to the inspector.
- `m_ready` in 1: inspector ready.
- `grant_valid` out 1: a packet is currently owned.
- `grant_id` out ID_W: index of the owning port.
- `timeout_pulse` out 1: one-cycle pulse when a flush completes.
- `timeout_port` out ID_W: port index of the last timeout.
- `pkt_count` out 32: packets forwarded, including flushed packets. Wraps.

## Operation

State machine, registered state: IDLE, PASS, FLUSH.

**IDLE**
- All `s_ready`=0, `m_valid`=0, `grant_valid`=0.
- Request vector: `req = s_valid & port_mask`.
- If `enable` and `req != 0`: select the first set bit of `req` scanning upward from `(last_grant+1) mod N_PORTS`, wrapping. Register the result in `grant_id` and go to PASS.
- After reset `last_grant` = N_PORTS-1, so port 0 has first priority.

**PASS**
- `grant_valid`=1.
- Stream signals are muxed combinationally:
  - `m_valid = s_valid[grant_id]`; `m_data`, `m_keep`, `m_last` come from the granted port.
  - `s_ready[grant_id] = m_ready`; all other `s_ready` = 0.
- Accepted beat = `m_valid & m_ready`.
- Accepted beat with `m_last`=1: `pkt_count`+1, `last_grant <= grant_id`, go to IDLE.
- Stall counter (16-bit):
  - Cleared on entry to PASS and on every accepted beat.
  - Increments each cycle with `s_valid[grant_id]`=0.
  - Does not increment while `m_valid`=1 and `m_ready`=0; inspector backpressure is never a timeout.
  - When it reaches `TIMEOUT_CYCLES` (nonzero), go to FLUSH.
- Changes to `port_mask` or `enable` during PASS do not affect the current packet.

**FLUSH**
- Granted `s_ready`=0.
- Drives the terminating beat: `m_valid`=1, `m_data`=0, `m_keep`=0, `m_last`=1.
- When `m_ready`=1:
  - `timeout_pulse`=1 for the next cycle.
  - `timeout_port <= grant_id`, `pkt_count`+1, `last_grant <= grant_id`.
  - Go to IDLE.
- The stalled source's remaining beats later arbitrate as a new packet; recovery is the source's responsibility.

**Reset** (any state, asynchronous):
- State → IDLE, `grant_id`=0, `timeout_port`=0, `pkt_count`=0, `timeout_pulse`=0, stall counter=0, `last_grant`=N_PORTS-1.
- All outputs 0 in IDLE.
- Reset mid-packet drops the grant immediately; no flush beat is emitted.

## Timing

- Arbitration latency: `s_valid` rising in IDLE gives a grant on the next edge. The first beat can be accepted in the cycle after that edge.
- Minimum gap between packets: one IDLE cycle. Peak throughput is therefore one packet per (beats+1) cycles.
- Data path: zero-latency combinational mux from `s_*` to `m_*` and from `m_ready` to `s_ready`. No registers in the data path.
- Timeout: FLUSH is entered exactly `TIMEOUT_CYCLES` cycles after the last accepted beat, or after PASS entry if no beat has been accepted.
- `timeout_pulse` asserts the cycle after the flush beat is accepted.
- Simultaneous requests are resolved only in IDLE. Requests arriving during PASS wait.
- A single-beat packet (`s_last`=1 on the first beat) is valid and takes PASS for one accepted cycle.

## Test plan

- Single port, 4-beat packet, `m_ready`=1: `grant_id`=0 one cycle after `s_valid`; 4 beats forwarded unchanged; `pkt_count`=1; back in IDLE after the `last` beat.
- Ports 0, 1, 3 requesting continuously, 2-beat packets: grant order 0,1,3,0,1,3; each packet atomic on `m_*`; no beat from another port is forwarded mid-packet.
- `port_mask`=4'b1101, all ports requesting: port 1 never granted. Clearing `enable` mid-packet lets the packet finish, then no new grant.
- `TIMEOUT_CYCLES`=8: port 2 sends 1 beat then drops `s_valid`. After 8 cycles, `m_valid`=1 with `m_keep`=0 and `m_last`=1; the next cycle has `timeout_pulse`=1 and `timeout_port`=2; `pkt_count`+1.
- Inspector holds `m_ready`=0 for 2000 cycles mid-packet with the source valid: no FLUSH; the packet completes once `m_ready` returns.
- Assert `rst` mid-PASS: all outputs 0 and state IDLE asynchronously. After release, port 0 wins a 4-port tie.
